// File: rtl/instr_encoder_pkg.sv
// Shared opcode/func constants, mnemonic ids, FSM encodings and descriptor types
// for the MIPS instruction encoder.
package instr_encoder_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_JAL   = 6'h03;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_JALR = 6'h09;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_NOR  = 6'h27;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;

  // R-type ids first, then I-type, then J-type; format is derived from the id range.
  localparam logic [4:0] MN_ADD  = 5'd0;
  localparam logic [4:0] MN_SUB  = 5'd1;
  localparam logic [4:0] MN_AND  = 5'd2;
  localparam logic [4:0] MN_OR   = 5'd3;
  localparam logic [4:0] MN_NOR  = 5'd4;
  localparam logic [4:0] MN_SLT  = 5'd5;
  localparam logic [4:0] MN_SLL  = 5'd6;
  localparam logic [4:0] MN_SRL  = 5'd7;
  localparam logic [4:0] MN_JR   = 5'd8;
  localparam logic [4:0] MN_JALR = 5'd9;
  localparam logic [4:0] MN_ADDI = 5'd10;
  localparam logic [4:0] MN_ANDI = 5'd11;
  localparam logic [4:0] MN_ORI  = 5'd12;
  localparam logic [4:0] MN_LW   = 5'd13;
  localparam logic [4:0] MN_SW   = 5'd14;
  localparam logic [4:0] MN_BEQ  = 5'd15;
  localparam logic [4:0] MN_BNE  = 5'd16;
  localparam logic [4:0] MN_J    = 5'd17;
  localparam logic [4:0] MN_JAL  = 5'd18;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

  typedef struct packed {
    logic [4:0]  mn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] imm;
  } enc_desc_t;

  typedef struct packed {
    logic        ok;
    logic [31:0] word;
  } enc_result_t;

  function automatic fmt_e mn_format(input logic [4:0] mn);
    if (mn <= MN_JALR) return FMT_R;
    else if (mn >= MN_J) return FMT_J;
    else return FMT_I;
  endfunction

endpackage

// File: rtl/instr_encoder_enc_fifo.sv
// DEPTH x W synchronous FIFO with full / almost-full / empty flags.
// A push and pop together at empty consume the word straight through.
module enc_fifo
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         afull_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, rd_ptr_q;
  logic [PW:0]  level;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty_o = (level == '0);
  assign full_o  = (level == (PW+1)'(DEPTH));
  assign afull_o = (level == (PW+1)'(DEPTH - 1));

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop) && !(empty_o && pop_i);
  assign rdata_o = empty_o ? wdata_i : mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs mnemonic descriptors into MIPS words and writes them to instruction memory.
// Optional immediate range checking: define INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_mn,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_shamt,
  input  logic [25:0]   in_imm,
  input  logic          in_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_busy,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-2:0] count
);

  function automatic enc_result_t encode(input enc_desc_t d);
    enc_result_t r;
    logic [5:0]  op;
    logic [5:0]  fn;
    op   = OPCODE_RTYPE;
    fn   = '0;
    r.ok = 1'b1;
    case (d.mn)
      MN_ADD:  fn = FUNC_ADD;
      MN_SUB:  fn = FUNC_SUB;
      MN_AND:  fn = FUNC_AND;
      MN_OR:   fn = FUNC_OR;
      MN_NOR:  fn = FUNC_NOR;
      MN_SLT:  fn = FUNC_SLT;
      MN_SLL:  fn = FUNC_SLL;
      MN_SRL:  fn = FUNC_SRL;
      MN_JR:   fn = FUNC_JR;
      MN_JALR: fn = FUNC_JALR;
      MN_ADDI: op = OPCODE_ADDI;
      MN_ANDI: op = OPCODE_ANDI;
      MN_ORI:  op = OPCODE_ORI;
      MN_LW:   op = OPCODE_LW;
      MN_SW:   op = OPCODE_SW;
      MN_BEQ:  op = OPCODE_BEQ;
      MN_BNE:  op = OPCODE_BNE;
      MN_J:    op = OPCODE_J;
      MN_JAL:  op = OPCODE_JAL;
      default: r.ok = 1'b0;
    endcase
    case (mn_format(d.mn))
      FMT_R:   r.word = {OPCODE_RTYPE, d.rs, d.rt, d.rd, d.shamt, fn};
      FMT_J:   r.word = {op, d.imm};
      default: r.word = {op, d.rs, d.rt, d.imm[15:0]};
    endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
    // Reject immediates that would not survive truncation to their field.
    case (d.mn)
      MN_ADDI, MN_LW, MN_SW, MN_BEQ, MN_BNE:
        if (!((&d.imm[25:15]) || !(|d.imm[25:15]))) r.ok = 1'b0;
      MN_ANDI, MN_ORI:
        if (|d.imm[25:16]) r.ok = 1'b0;
      MN_SLL, MN_SRL:
        if (|d.imm) r.ok = 1'b0;
      default: ;
    endcase
`endif
    return r;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-2:0] count_q, count_d;
  logic          err_q, err_d;
  logic          enc_vld_p1_q;
  logic [31:0]   enc_word_p1_q;

  enc_desc_t   desc;
  enc_result_t enc_r;
  logic        accept, wr_ok;
  logic        fifo_full, fifo_afull, fifo_empty;
  logic [31:0] fifo_rdata;
  logic        active;

  assign desc   = {in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm};
  assign enc_r  = encode(desc);
  assign active = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

  // The encode register is a hidden extra slot, so stop accepting one word early.
  assign in_ready = (state_q == ST_LOAD) && !fifo_full && !(fifo_afull && enc_vld_p1_q);
  assign accept   = in_valid && in_ready;
  assign imem_we  = active && !fifo_empty;
  assign wr_ok    = imem_we && !imem_busy;

  enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (enc_vld_p1_q),
    .wdata_i (enc_word_p1_q),
    .pop_i   (wr_ok),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .afull_o (fifo_afull),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty && !enc_vld_p1_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (accept && !enc_r.ok) err_d = 1'b1;
    if (wr_ok) begin
      addr_d  = addr_q + AW'(4);
      count_d = count_q + (AW-1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      count_q       <= '0;
      err_q         <= 1'b0;
      enc_vld_p1_q  <= 1'b0;
      enc_word_p1_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      err_q        <= err_d;
      // Encode stage -> FIFO push on the following cycle
      enc_vld_p1_q <= accept && enc_r.ok;
      if (accept) enc_word_p1_q <= enc_r.word;
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = fifo_rdata;
  assign busy       = active;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign count      = count_q;

endmodule
